ecc_mem_access_ctrl: RTL and testbench

- Clocked transaction controller in front of the combinational ECC/bypass datapath. That datapath has a 16-bit processor side, two 16-bit memory halves, a 3-bit `sel` and a 3-bit decoder `flag`.
- Accepts single-word read/write requests from the processor side and drives the datapath `sel` and write data.
- Sequences enable/write strobes to the two memory halves and waits out memory read latency.
- Classifies decoder flags, optionally scrubs corrected words back to memory, and keeps saturating error counters.

---
 rtl/ecc_mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ecc_mem_access_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_mem_access_ctrl.sv
// Transaction controller in front of the ECC/bypass datapath.
// Sequences memory strobes and read latency, classifies flags, scrubs and counts errors.
module ecc_mem_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        mode_i,
  input  logic [15:0]       wdata_i,
  input  logic              scrub_en_i,
  input  logic              clr_cnt_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic [15:0]       rdata_o,
  output logic              err_corr_o,
  output logic              err_uncorr_o,
  output logic [2:0]        ecc_sel_o,
  output logic [15:0]       ecc_wdata_o,
  input  logic [15:0]       ecc_rdata_i,
  input  logic [2:0]        ecc_flag_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_up_o,
  output logic              mem_en_down_o,
  output logic              mem_we_o,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic [CNT_W-1:0]  uncorr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_SCRUB,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                corr_q, corr_d;
  logic                unc_q, unc_d;
  logic [3:0]          lat_q, lat_d;
  logic [CNT_W-1:0]    ccnt_q, ccnt_d;
  logic [CNT_W-1:0]    ucnt_q, ucnt_d;
  logic                flag_corr;
  logic                flag_unc;
  logic                active;

  // Only the TBEC_RSC path reports meaningful decoder flags.
  always_comb begin
    flag_corr = 1'b0;
    flag_unc  = 1'b0;
    if (mode_q == 2'b10) begin
      flag_unc  = (ecc_flag_i == 3'b111);
      flag_corr = (ecc_flag_i != 3'b000) && !flag_unc;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    corr_d  = corr_q;
    unc_d   = unc_q;
    lat_d   = lat_q;
    ccnt_d  = ccnt_q;
    ucnt_d  = ucnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          mode_d  = mode_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          corr_d  = 1'b0;
          unc_d   = 1'b0;
          lat_d   = 4'd0;
          state_d = we_i ? S_WR : S_RD;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      S_RD: begin
        if (lat_q == LAT_LAST) begin
          rdata_d = ecc_rdata_i;
          corr_d  = flag_corr;
          unc_d   = flag_unc;
          if (flag_corr && scrub_en_i) begin
            wdata_d = ecc_rdata_i;
            state_d = S_SCRUB;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_SCRUB: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (corr_q && (ccnt_q != '1)) ccnt_d = ccnt_q + 1'b1;
        if (unc_q && (ucnt_q != '1))  ucnt_d = ucnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Clear has priority over a coincident increment.
    if (clr_cnt_i) begin
      ccnt_d = '0;
      ucnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
      lat_q   <= 4'd0;
      ccnt_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      lat_q   <= lat_d;
      ccnt_q  <= ccnt_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign active = (state_q == S_WR) || (state_q == S_RD) ||
                  (state_q == S_SCRUB);

  assign busy_o        = (state_q != S_IDLE);
  assign ack_o         = (state_q == S_DONE);
  assign err_corr_o    = ack_o && corr_q;
  assign err_uncorr_o  = ack_o && unc_q;
  assign rdata_o       = rdata_q;
  assign ecc_sel_o     = {1'b0, mode_q};
  assign ecc_wdata_o   = wdata_q;
  assign mem_addr_o    = addr_q;
  assign mem_en_up_o   = active && (mode_q != 2'b01);
  assign mem_en_down_o = active && (mode_q != 2'b00);
  assign mem_we_o      = (state_q == S_WR) || (state_q == S_SCRUB);
  assign corr_cnt_o    = ccnt_q;
  assign uncorr_cnt_o  = ucnt_q;

endmodule

// File: tb/tb_ecc_mem_access_ctrl.sv
// Directed bench for ecc_mem_access_ctrl.
// Built with RD_LAT=2 and CNT_W=2 so counter saturation is reachable.
module tb_ecc_mem_access_ctrl;

  localparam int AW = 12;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [1:0]    mode_i;
  logic [15:0]   wdata_i;
  logic          scrub_en_i;
  logic          clr_cnt_i;
  logic          busy_o;
  logic          ack_o;
  logic [15:0]   rdata_o;
  logic          err_corr_o;
  logic          err_uncorr_o;
  logic [2:0]    ecc_sel_o;
  logic [15:0]   ecc_wdata_o;
  logic [15:0]   ecc_rdata_i;
  logic [2:0]    ecc_flag_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_en_up_o;
  logic          mem_en_down_o;
  logic          mem_we_o;
  logic [CW-1:0] corr_cnt_o;
  logic [CW-1:0] uncorr_cnt_o;

  int n_err = 0;
  int n_chk = 0;
  int lat;
  int acks;

  always #5 clk_i = ~clk_i;

  ecc_mem_access_ctrl #(
    .ADDR_W(AW),
    .RD_LAT(2),
    .CNT_W (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .mode_i       (mode_i),
    .wdata_i      (wdata_i),
    .scrub_en_i   (scrub_en_i),
    .clr_cnt_i    (clr_cnt_i),
    .busy_o       (busy_o),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .err_corr_o   (err_corr_o),
    .err_uncorr_o (err_uncorr_o),
    .ecc_sel_o    (ecc_sel_o),
    .ecc_wdata_o  (ecc_wdata_o),
    .ecc_rdata_i  (ecc_rdata_i),
    .ecc_flag_i   (ecc_flag_i),
    .mem_addr_o   (mem_addr_o),
    .mem_en_up_o  (mem_en_up_o),
    .mem_en_down_o(mem_en_down_o),
    .mem_we_o     (mem_we_o),
    .corr_cnt_o   (corr_cnt_o),
    .uncorr_cnt_o (uncorr_cnt_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue a read, return at the ack cycle; lat is cycles since accept.
  task automatic rd(input logic [1:0] m, input logic [2:0] f,
                    input logic [15:0] d, input logic s,
                    output int l);
    we_i        = 1'b0;
    mode_i      = m;
    addr_i      = 12'h100;
    ecc_flag_i  = f;
    ecc_rdata_i = d;
    scrub_en_i  = s;
    req_i       = 1'b1;
    step();
    req_i = 1'b0;
    l = 1;
    while (!ack_o && l < 12) begin
      step();
      l++;
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    req_i       = 1'b0;
    we_i        = 1'b0;
    addr_i      = '0;
    mode_i      = 2'b00;
    wdata_i     = '0;
    scrub_en_i  = 1'b0;
    clr_cnt_i   = 1'b0;
    ecc_rdata_i = '0;
    ecc_flag_i  = '0;
    step();
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 0);
    chk("rst_sel", ecc_sel_o, 0);
    chk("rst_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);
    rst_i = 1'b0;
    step();

    // write, mode 01
    we_i    = 1'b1;
    mode_i  = 2'b01;
    addr_i  = 12'h005;
    wdata_i = 16'hA5A5;
    req_i   = 1'b1;
    step();
    req_i = 1'b0;
    chk("wr_c1_sel", ecc_sel_o, 3'b001);
    chk("wr_c1_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 3'b011);
    chk("wr_c1_addr", mem_addr_o, 12'h005);
    chk("wr_c1_wd", ecc_wdata_o, 16'hA5A5);
    chk("wr_c1_ack", ack_o, 0);
    step();
    chk("wr_c2_ack", ack_o, 1);
    chk("wr_c2_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 0);
    chk("wr_c2_err", {err_corr_o, err_uncorr_o}, 0);
    step();
    chk("wr_c3_idle", {busy_o, ack_o}, 0);

    // clean read, mode 10
    we_i        = 1'b0;
    mode_i      = 2'b10;
    ecc_rdata_i = 16'h1234;
    ecc_flag_i  = 3'b000;
    req_i       = 1'b1;
    step();
    req_i = 1'b0;
    chk("rd_c1_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 3'b110);
    chk("rd_c1_sel", ecc_sel_o, 3'b010);
    step();
    chk("rd_c2_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 3'b110);
    chk("rd_c2_ack", ack_o, 0);
    step();
    chk("rd_c3_ack", ack_o, 1);
    chk("rd_c3_data", rdata_o, 16'h1234);
    chk("rd_c3_err", {err_corr_o, err_uncorr_o}, 0);
    step();
    chk("rd_cnt", {corr_cnt_o, uncorr_cnt_o}, 0);

    // correctable read with scrub
    we_i        = 1'b0;
    mode_i      = 2'b10;
    ecc_rdata_i = 16'hBEEF;
    ecc_flag_i  = 3'b001;
    scrub_en_i  = 1'b1;
    req_i       = 1'b1;
    step();
    req_i = 1'b0;
    step();
    chk("sc_c2_ack", ack_o, 0);
    step();
    chk("sc_c3_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 3'b111);
    chk("sc_c3_wd", ecc_wdata_o, 16'hBEEF);
    chk("sc_c3_ack", ack_o, 0);
    step();
    chk("sc_c4_ack", ack_o, 1);
    chk("sc_c4_err", {err_corr_o, err_uncorr_o}, 2'b10);
    chk("sc_c4_data", rdata_o, 16'hBEEF);
    step();
    chk("sc_cnt", corr_cnt_o, 1);
    chk("sc_wd_hold", ecc_wdata_o, 16'hBEEF);
    chk("sc_err_idle", {err_corr_o, err_uncorr_o}, 0);

    // uncorrectable read, scrub enabled but not taken
    rd(2'b10, 3'b111, 16'h5555, 1'b1, lat);
    chk("un_lat", lat, 3);
    chk("un_err", {err_corr_o, err_uncorr_o}, 2'b01);
    step();
    chk("un_cnt", uncorr_cnt_o, 1);

    // same read in mode 11 is clean
    rd(2'b11, 3'b111, 16'h5555, 1'b1, lat);
    chk("m11_lat", lat, 3);
    chk("m11_err", {err_corr_o, err_uncorr_o}, 0);
    step();
    chk("m11_cnt", {corr_cnt_o, uncorr_cnt_o}, {2'd1, 2'd1});

    // saturation
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    chk("clr_idle", {corr_cnt_o, uncorr_cnt_o}, 0);
    for (int i = 0; i < 4; i++) begin
      rd(2'b10, 3'b010, 16'h0001, 1'b0, lat);
      step();
    end
    chk("sat_4", corr_cnt_o, 3);
    rd(2'b10, 3'b100, 16'h0002, 1'b0, lat);
    chk("sat_lat", lat, 3);
    step();
    chk("sat_5", corr_cnt_o, 3);
    rd(2'b10, 3'b100, 16'h0003, 1'b0, lat);
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    chk("clr_ack", corr_cnt_o, 0);

    // reset during RD cycle 1
    we_i        = 1'b0;
    mode_i      = 2'b10;
    addr_i      = 12'h3C3;
    ecc_flag_i  = 3'b001;
    ecc_rdata_i = 16'hCAFE;
    req_i       = 1'b1;
    step();
    req_i = 1'b0;
    chk("ab_busy_pre", busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("ab_busy", busy_o, 0);
    chk("ab_strb", {mem_en_up_o, mem_en_down_o, mem_we_o}, 0);
    chk("ab_addr", mem_addr_o, 0);
    chk("ab_sel", ecc_sel_o, 0);
    step();
    rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ack_o) acks++;
    end
    chk("ab_noack", acks, 0);

    // req held through a whole read
    we_i        = 1'b0;
    mode_i      = 2'b10;
    addr_i      = 12'h0AA;
    ecc_flag_i  = 3'b000;
    ecc_rdata_i = 16'h0F0F;
    req_i       = 1'b1;
    step();
    addr_i = 12'h0BB;
    chk("hd_c1_busy", busy_o, 1);
    step();
    chk("hd_c2_addr", mem_addr_o, 12'h0AA);
    step();
    chk("hd_c3_ack", ack_o, 1);
    chk("hd_c3_addr", mem_addr_o, 12'h0AA);
    step();
    chk("hd_c4_idle", {busy_o, ack_o}, 0);
    step();
    chk("hd_c5_busy", busy_o, 1);
    chk("hd_c5_addr", mem_addr_o, 12'h0BB);
    req_i = 1'b0;
    lat = 0;
    while (busy_o && lat < 12) begin
      step();
      lat++;
    end
    chk("hd_drain", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
